// File: rtl/ac_cmd_sequencer.sv
// Command sequencer for the 16-bit accumulator: expands commands into one-hot strobe trains
// and tracks a shadow copy of the accumulator so the controller can branch on zero locally.
module ac_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] alu_in,
  output logic             mux_load,
  output logic             alu_load,
  output logic             inc,
  output logic             clear,
  output logic             dec,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] ac_shadow,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int B_MUX = 4;
  localparam int B_ALU = 3;
  localparam int B_INC = 2;
  localparam int B_CLR = 1;
  localparam int B_DEC = 0;

  state_t           r_state, w_nxt_state;
  logic [4:0]       r_sel, w_nxt_sel;
  logic [4:0]       r_strb, w_nxt_strb;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_done, w_nxt_done;
  logic             r_err, w_nxt_err;
  logic [WIDTH-1:0] r_mux, w_nxt_mux;
  logic [WIDTH-1:0] r_shadow, w_nxt_shadow;

  logic [4:0]       w_op_sel;
  logic [CNT_W-1:0] w_op_n;
  logic             w_illegal;

  // Opcode decode: selected strobe and total strobe count N.
  always_comb begin
    w_op_sel  = '0;
    w_op_n    = '0;
    w_illegal = 1'b0;
    case (cmd_op)
      3'b001: begin w_op_sel[B_CLR] = 1'b1; w_op_n = CNT_W'(1); end
      3'b010: begin w_op_sel[B_MUX] = 1'b1; w_op_n = CNT_W'(1); end
      3'b011: begin w_op_sel[B_ALU] = 1'b1; w_op_n = CNT_W'(1); end
      3'b100: begin w_op_sel[B_INC] = 1'b1; w_op_n = cmd_count; end
      3'b101: begin w_op_sel[B_DEC] = 1'b1; w_op_n = cmd_count; end
      3'b110, 3'b111: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // r_cnt holds the strobes still to issue after the current cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_strb  = '0;
    w_nxt_cnt   = r_cnt;
    w_nxt_done  = 1'b0;
    w_nxt_err   = 1'b0;
    w_nxt_mux   = r_mux;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nxt_state = S_RUN;
          w_nxt_sel   = w_op_sel;
          w_nxt_mux   = cmd_data;
          w_nxt_err   = w_illegal;
          if (w_op_n != '0) begin
            w_nxt_strb = w_op_sel;
            w_nxt_cnt  = w_op_n - CNT_W'(1);
            w_nxt_done = (w_op_n == CNT_W'(1));
          end else begin
            w_nxt_cnt  = '0;
            w_nxt_done = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt != '0) begin
          w_nxt_strb = r_sel;
          w_nxt_cnt  = r_cnt - CNT_W'(1);
          w_nxt_done = (r_cnt == CNT_W'(1));
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Shadow follows the accumulator using the strobes live in this cycle.
  always_comb begin
    w_nxt_shadow = r_shadow;
    if (r_strb[B_CLR])      w_nxt_shadow = '0;
    else if (r_strb[B_MUX]) w_nxt_shadow = r_mux;
    else if (r_strb[B_ALU]) w_nxt_shadow = alu_in;
    else if (r_strb[B_INC]) w_nxt_shadow = r_shadow + WIDTH'(1);
    else if (r_strb[B_DEC]) w_nxt_shadow = r_shadow - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_strb   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mux    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_sel    <= w_nxt_sel;
      r_strb   <= w_nxt_strb;
      r_cnt    <= w_nxt_cnt;
      r_done   <= w_nxt_done;
      r_err    <= w_nxt_err;
      r_mux    <= w_nxt_mux;
      r_shadow <= w_nxt_shadow;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign mux_load  = r_strb[B_MUX];
  assign alu_load  = r_strb[B_ALU];
  assign inc       = r_strb[B_INC];
  assign clear     = r_strb[B_CLR];
  assign dec       = r_strb[B_DEC];
  assign mux_out   = r_mux;
  assign ac_shadow = r_shadow;
  assign zero      = (r_shadow == '0);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_ac_cmd_sequencer.sv
// Bench for ac_cmd_sequencer: directed scenarios plus random commands, each cycle compared
// against a per-command model of strobe train length, completion timing and accumulator value.
module tb_ac_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_count;
  logic [15:0] alu_in;
  logic        mux_load, alu_load, inc, clear, dec;
  logic [15:0] mux_out, ac_shadow;
  logic        zero, busy, done, err;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_shadow;
  logic [15:0] m_mux;

  always #5 clk = ~clk;

  ac_cmd_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .alu_in    (alu_in),
    .mux_load  (mux_load),
    .alu_load  (alu_load),
    .inc       (inc),
    .clear     (clear),
    .dec       (dec),
    .mux_out   (mux_out),
    .ac_shadow (ac_shadow),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  wire [4:0] strb = {mux_load, alu_load, inc, clear, dec};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe expected for an opcode, ordered {mux_load, alu_load, inc, clear, dec}.
  function automatic logic [4:0] op_strobe(input logic [2:0] op);
    case (op)
      3'd1:    return 5'b00010;
      3'd2:    return 5'b10000;
      3'd3:    return 5'b01000;
      3'd4:    return 5'b00100;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic int op_len(input logic [2:0] op, input logic [7:0] cnt);
    case (op)
      3'd1, 3'd2, 3'd3: return 1;
      3'd4, 3'd5:       return int'(cnt);
      default:          return 0;
    endcase
  endfunction

  task automatic chk_reset_state(input string tag);
    chk_eq({tag, "_strb"},  32'(strb), 0);
    chk_eq({tag, "_ready"}, 32'(cmd_ready), 1);
    chk_eq({tag, "_busy"},  32'(busy), 0);
    chk_eq({tag, "_done"},  32'(done), 0);
    chk_eq({tag, "_err"},   32'(err), 0);
    chk_eq({tag, "_shadow"}, 32'(ac_shadow), 0);
    chk_eq({tag, "_zero"},  32'(zero), 1);
    chk_eq({tag, "_mux"},   32'(mux_out), 0);
  endtask

  // Issues one command in an idle cycle and checks every cycle it occupies.
  // alu_v < 0 drives random alu_in; hold keeps cmd_valid high while busy;
  // abort_at > 0 asserts rst right after that cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] data, input logic [7:0] cnt,
                         input int alu_v, input bit hold, input int abort_at);
    int n;
    int m;
    logic [4:0]  oh;
    logic [15:0] a;
    n  = op_len(op, cnt);
    m  = (n < 1) ? 1 : n;
    oh = op_strobe(op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    alu_in    = 16'($urandom);
    chk_eq("idle_ready",  32'(cmd_ready), 1);
    chk_eq("idle_strb",   32'(strb), 0);
    chk_eq("idle_shadow", 32'(ac_shadow), 32'(m_shadow));
    chk_eq("idle_zero",   32'(zero), 32'(m_shadow == 16'h0));
    m_mux = data;
    for (int k = 1; k <= m; k++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      a = (alu_v < 0) ? 16'($urandom) : 16'(alu_v);
      alu_in = a;
      chk_eq("strobes",   32'(strb), (k <= n) ? 32'(oh) : 0);
      chk_eq("done",      32'(done), 32'(k == m));
      chk_eq("err",       32'(err), 32'((k == 1) && (op >= 3'd6)));
      chk_eq("busy",      32'(busy), 1);
      chk_eq("ready_run", 32'(cmd_ready), 0);
      chk_eq("mux_out",   32'(mux_out), 32'(m_mux));
      chk_eq("shadow",    32'(ac_shadow), 32'(m_shadow));
      chk_eq("zero",      32'(zero), 32'(m_shadow == 16'h0));
      if (k <= n) begin
        case (op)
          3'd1: m_shadow = 16'h0;
          3'd2: m_shadow = m_mux;
          3'd3: m_shadow = a;
          3'd4: m_shadow = m_shadow + 16'h1;
          3'd5: m_shadow = m_shadow - 16'h1;
          default: ;
        endcase
      end
      if (k == abort_at) begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_reset_state("abort");
        rst      = 1'b0;
        m_shadow = 16'h0;
        m_mux    = 16'h0;
        return;
      end
    end
    cmd_valid = hold;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 16'h0;
    cmd_count = 8'h0;
    alu_in    = 16'h0;
    m_shadow  = 16'h0;
    m_mux     = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    run_cmd(3'd2, 16'h1234, 8'd0, -1, 1'b0, 0);
    run_cmd(3'd2, 16'hFFFD, 8'd0, -1, 1'b0, 0);
    run_cmd(3'd4, 16'h0000, 8'd5, -1, 1'b0, 0);
    run_cmd(3'd5, 16'h0000, 8'd3, -1, 1'b1, 0);
    run_cmd(3'd5, 16'h0000, 8'd3, -1, 1'b0, 0);
    run_cmd(3'd3, 16'h0000, 8'd0, 16'h00AA, 1'b0, 0);
    run_cmd(3'd1, 16'h0000, 8'd0, -1, 1'b0, 0);
    run_cmd(3'd2, 16'h0042, 8'd0, -1, 1'b0, 0);
    run_cmd(3'd6, 16'h5555, 8'd9, -1, 1'b0, 0);
    run_cmd(3'd4, 16'h0000, 8'd0, -1, 1'b0, 0);
    run_cmd(3'd7, 16'hAAAA, 8'd1, -1, 1'b0, 0);
    run_cmd(3'd0, 16'h0F0F, 8'd4, -1, 1'b0, 0);
    run_cmd(3'd5, 16'h0000, 8'd255, -1, 1'b0, 0);
    run_cmd(3'd4, 16'h0000, 8'd200, -1, 1'b0, 50);
    run_cmd(3'd2, 16'hBEEF, 8'd0, -1, 1'b0, 0);

    for (int i = 0; i < 120; i++) begin
      logic [2:0] op;
      logic [7:0] cnt;
      op  = 3'($urandom_range(0, 7));
      cnt = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) cnt = 8'd255;
      run_cmd(op, 16'($urandom), cnt, -1, 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    cmd_valid = 1'b0;
    chk_eq("final_shadow", 32'(ac_shadow), 32'(m_shadow));
    chk_eq("final_ready",  32'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_cmd_sequencer.md
# ac_cmd_sequencer

- Command-side initiator for the 16-bit accumulator register of the matrix-multiplier datapath.
- Accepts commands over a valid/ready interface and drives the register's one-hot control strobes (`mux_load`, `alu_load`, `inc`, `clear`, `dec`) plus the mux data word.
- Expands repeat counts into strobe trains and keeps a shadow copy of the accumulator value, so the controller can branch on zero without reading the datapath.

## Interface
- `WIDTH`, 16, accumulator and data width
- `CNT_W`, 8, repeat-count width
- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, reset; synchronous, active-high
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, sequencer can accept a command
- `cmd_op` in 3, opcode: 000 NOP, 001 CLEAR, 010 LOAD, 011 ALU, 100 INC, 101 DEC, 110/111 illegal
- `cmd_data` in WIDTH, LOAD operand
- `cmd_count` in CNT_W, repeat count for INC/DEC
- `alu_in` in WIDTH, ALU result as seen by the accumulator; used for the shadow only
- `mux_load`, `alu_load`, `inc`, `clear`, `dec` out 1 each, accumulator strobes
- `mux_out` out WIDTH, data for the accumulator mux input
- `ac_shadow` out WIDTH, modelled accumulator value
- `zero` out 1, `ac_shadow == 0`
- `busy` out 1, command in progress
- `done` out 1, one-cycle completion pulse
- `err` out 1, one-cycle illegal-opcode pulse

## Operation
**States**
- IDLE: `cmd_ready`=1.
- RUN: strobes issued, `cmd_ready`=0.

**Accept and run**
- A command is accepted at an edge where `cmd_valid && cmd_ready`.
- At acceptance the sequencer latches op and count, latches `cmd_data` into `mux_out` (for every op), and goes to RUN.
- Strobe count N per op:
  - CLEAR, LOAD, ALU: N=1.
  - INC, DEC: N=`cmd_count`.
  - NOP, illegal, or INC/DEC with count 0: N=0.

**Strobes**
- At most one strobe is high in any cycle; all strobes are registered.
- Op-to-strobe map:
  - CLEAR → `clear`.
  - LOAD → `mux_load`.
  - ALU → `alu_load`.
  - INC → `inc`.
  - DEC → `dec`.

**Shadow register**
- `ac_shadow` updates at the end of each strobe cycle, exactly as the accumulator does:
  - `clear` → 0.
  - `mux_load` → `mux_out`.
  - `alu_load` → `alu_in` sampled in that cycle.
  - `inc` → +1.
  - `dec` → −1.
- Arithmetic is modulo 2^WIDTH: FFFF+1 → 0000, 0000−1 → FFFF.

**Other outputs**
- `zero` is combinational from `ac_shadow`.
- `mux_out` holds its value until the next acceptance.

**Reset values**
- All strobes 0.
- `done`, `err`, `busy` 0.
- `cmd_ready` 1 (state IDLE).
- `mux_out` 0.
- `ac_shadow` 0, so `zero` 1.
- Repeat counter 0.

## Timing
**Per-command timing** (acceptance edge at end of cycle T)
- Strobes are high in cycles T+1 … T+N.
- `done` is high in cycle T+max(N,1), coincident with the last strobe.
- `busy` and `cmd_ready`=0 cover cycles T+1 … T+max(N,1).
- `cmd_ready` returns to 1 in cycle T+max(N,1)+1.
- Back-to-back throughput: one command every max(N,1)+1 cycles.

**Error and no-op cases**
- `err` pulses in cycle T+1, together with `done`; no strobe is issued and the shadow is unchanged.
- NOP and count-0 INC/DEC: `done` in T+1, no strobe.

**Boundary cases**
- Count 2^CNT_W−1 produces exactly that many strobes, with no off-by-one.
- `cmd_valid` while busy: the command is not accepted, and the inputs must be held by the sender.
- `alu_in` is sampled only in the `alu_load` cycle.

**Reset during RUN**
- At the reset edge the strobes drop, the counter clears and the state goes to IDLE; the partial train is abandoned.
- No `done` is issued.
- `ac_shadow` goes to 0, matching the accumulator power-up value.

## Test plan
- Reset, then LOAD `cmd_data`=1234 → `mux_load` for 1 cycle, `mux_out`=1234, `ac_shadow`=1234, `done` coincident, `cmd_ready` back after 2 cycles.
- LOAD FFFD, then INC count 5 → exactly 5 `inc` cycles, shadow wraps FFFD→…→0002, `zero` high only for the cycle after the 3rd inc.
- DEC count 3 from 0002 → 3 `dec` cycles, shadow ends FFFF; the op is then repeated back-to-back with `cmd_valid` held high → second command accepted one cycle after the first `done`.
- ALU with `alu_in`=00AA during the strobe cycle, then CLEAR → `alu_load` 1 cycle, shadow 00AA, then `clear` 1 cycle, shadow 0000, `zero` 1.
- Opcode 110 and INC count 0 → `done` (plus `err` for 110) in T+1, no strobes, shadow unchanged.
- INC count 200, `rst` asserted after the 50th strobe → strobes stop the next cycle, no `done`, shadow 0, `cmd_ready` 1; a new LOAD is accepted normally.
